// File: rtl/mem_resp_router.sv
// Tracks issued icache/load memory requests by transaction tag and routes the returning data to its owner.
// Optional build macro MEM_RESP_STATS_EN adds per-owner response counters.
module mem_resp_router #(
    parameter int NUM_TAGS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        icache_req_sent,
    input  logic        load_req_sent,
    input  logic        store_req_sent,
    input  logic [31:0] proc2mem_addr,
    input  logic [3:0]  mem2proc_transaction_tag,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_data_tag,
    output logic        icache_resp_val,
    output logic [31:0] icache_resp_addr,
    output logic [63:0] icache_resp_data,
    output logic        load_resp_val,
    output logic [31:0] load_resp_addr,
    output logic [63:0] load_resp_data,
    output logic        icache_req_accepted,
    output logic        load_req_accepted,
    output logic [4:0]  outstanding,
    output logic        orphan_err
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0] icache_resp_cnt,
    output logic [31:0] load_resp_cnt
`endif
);

    // Responses are valid-only pulses with no ready: the consumer must take
    // a response in the single cycle its resp_val is high.
    localparam logic [4:0] TAG_LIMIT = 5'(NUM_TAGS);

    logic [NUM_TAGS-1:0] valid_q;
    logic [NUM_TAGS-1:0] valid_next;
    logic [NUM_TAGS-1:0] owner_load_q;
    logic [31:0]         addr_q [NUM_TAGS];

    logic       t_ok;
    logic       d_ok;
    logic       alloc;
    logic       d_tracked;
    logic       d_orphan;
    logic       overwrite;
    logic [4:0] count_next;

    assign t_ok = (mem2proc_transaction_tag != 4'd0) && ({1'b0, mem2proc_transaction_tag} < TAG_LIMIT);
    assign d_ok = (mem2proc_data_tag != 4'd0) && ({1'b0, mem2proc_data_tag} < TAG_LIMIT);

    // Stores never allocate: their data never comes back.
    assign alloc     = (icache_req_sent | load_req_sent) & t_ok;
    assign d_tracked = d_ok & valid_q[mem2proc_data_tag];
    assign d_orphan  = (mem2proc_data_tag != 4'd0) & ~d_tracked;
    assign overwrite = alloc & valid_q[mem2proc_transaction_tag]
                     & ~(d_tracked & (mem2proc_data_tag == mem2proc_transaction_tag));

    // A simultaneous icache+load issue is treated as a load.
    assign icache_req_accepted = icache_req_sent & ~load_req_sent & t_ok;
    assign load_req_accepted   = load_req_sent & t_ok;

    always_comb begin
        valid_next = valid_q;
        if (d_tracked) valid_next[mem2proc_data_tag] = 1'b0;
        if (alloc)     valid_next[mem2proc_transaction_tag] = 1'b1;
        count_next = 5'd0;
        for (int i = 1; i < NUM_TAGS; i++) begin
            count_next = count_next + 5'(valid_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (alloc) begin
            owner_load_q[mem2proc_transaction_tag] <= load_req_sent;
            addr_q[mem2proc_transaction_tag]       <= proc2mem_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q          <= '0;
            outstanding      <= 5'd0;
            orphan_err       <= 1'b0;
            icache_resp_val  <= 1'b0;
            icache_resp_addr <= '0;
            icache_resp_data <= '0;
            load_resp_val    <= 1'b0;
            load_resp_addr   <= '0;
            load_resp_data   <= '0;
        end else begin
            valid_q     <= valid_next;
            outstanding <= count_next;
            if (d_orphan | overwrite) orphan_err <= 1'b1;
            // The response reads the pre-edge entry, so a same-tag re-allocate is safe.
            icache_resp_val  <= d_tracked & ~owner_load_q[mem2proc_data_tag];
            load_resp_val    <= d_tracked &  owner_load_q[mem2proc_data_tag];
            icache_resp_addr <= (d_tracked & ~owner_load_q[mem2proc_data_tag]) ? addr_q[mem2proc_data_tag] : '0;
            icache_resp_data <= (d_tracked & ~owner_load_q[mem2proc_data_tag]) ? mem2proc_data : '0;
            load_resp_addr   <= (d_tracked &  owner_load_q[mem2proc_data_tag]) ? addr_q[mem2proc_data_tag] : '0;
            load_resp_data   <= (d_tracked &  owner_load_q[mem2proc_data_tag]) ? mem2proc_data : '0;
        end
    end

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            icache_resp_cnt <= 32'd0;
            load_resp_cnt   <= 32'd0;
        end else begin
            icache_resp_cnt <= icache_resp_cnt + 32'(icache_resp_val);
            load_resp_cnt   <= load_resp_cnt + 32'(load_resp_val);
        end
    end
`endif

endmodule

// File: tb/tb_mem_resp_router.sv
// Scoreboard bench for mem_resp_router: directed scenarios plus randomized traffic against a tag-table model.
// Stats checks are compiled in when MEM_RESP_STATS_EN is defined.
module tb_mem_resp_router;

    logic        clock = 1'b0;
    logic        reset;
    logic        icache_req_sent, load_req_sent, store_req_sent;
    logic [31:0] proc2mem_addr;
    logic [3:0]  mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_data_tag;
    logic        icache_resp_val, load_resp_val;
    logic [31:0] icache_resp_addr, load_resp_addr;
    logic [63:0] icache_resp_data, load_resp_data;
    logic        icache_req_accepted, load_req_accepted;
    logic [4:0]  outstanding;
    logic        orphan_err;
`ifdef MEM_RESP_STATS_EN
    logic [31:0] icache_resp_cnt, load_resp_cnt;
`endif

    mem_resp_router #(.NUM_TAGS(16)) dut (
        .clock(clock), .reset(reset),
        .icache_req_sent(icache_req_sent), .load_req_sent(load_req_sent),
        .store_req_sent(store_req_sent), .proc2mem_addr(proc2mem_addr),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag),
        .icache_resp_val(icache_resp_val), .icache_resp_addr(icache_resp_addr),
        .icache_resp_data(icache_resp_data),
        .load_resp_val(load_resp_val), .load_resp_addr(load_resp_addr),
        .load_resp_data(load_resp_data),
        .icache_req_accepted(icache_req_accepted), .load_req_accepted(load_req_accepted),
        .outstanding(outstanding), .orphan_err(orphan_err)
`ifdef MEM_RESP_STATS_EN
        , .icache_resp_cnt(icache_resp_cnt), .load_resp_cnt(load_resp_cnt)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [96:0] exp_q[$];      // {is_load, addr, data}
    int          exp_cyc_q[$];  // cycle in which the response must be visible

    // Reference tag table: what memory currently owes us, keyed by tag.
    bit          m_valid [16];
    bit          m_is_load [16];
    logic [31:0] m_addr [16];
    bit          m_orphan;
    int          m_ic_cnt, m_ld_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 1; i < 16; i++) c += m_valid[i] ? 1 : 0;
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_orphan = 0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        logic        got;
        logic        exp_here;
        logic [96:0] seen;
        if (icache_resp_val && load_resp_val) chk("one_hot_resp", 2'b11, 2'b01);
        if (!icache_resp_val) chk("icache_idle_zero", {icache_resp_addr, icache_resp_data}, '0);
        if (!load_resp_val)   chk("load_idle_zero", {load_resp_addr, load_resp_data}, '0);
        got = icache_resp_val | load_resp_val;
        exp_here = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] <= cyc);
        if (got || exp_here) begin
            if (got && exp_here) begin
                seen = load_resp_val ? {1'b1, load_resp_addr, load_resp_data}
                                     : {1'b0, icache_resp_addr, icache_resp_data};
                chk("resp_content", seen, exp_q[0]);
                if (exp_q[0][96]) m_ld_cnt++; else m_ic_cnt++;
            end else begin
                chk("resp_presence", got, exp_here);
            end
            if (exp_here) begin
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic drive_cycle(input logic is, input logic ls, input logic ss,
                               input logic [31:0] a, input logic [3:0] tt,
                               input logic [63:0] d, input logic [3:0] dt);
        icache_req_sent = is; load_req_sent = ls; store_req_sent = ss;
        proc2mem_addr = a; mem2proc_transaction_tag = tt;
        mem2proc_data = d; mem2proc_data_tag = dt;
        #1;
        chk("icache_accepted", icache_req_accepted, is & ~ls & (tt != 0));
        chk("load_accepted", load_req_accepted, ls & (tt != 0));
        if (dt != 0) begin
            if (m_valid[dt]) begin
                exp_q.push_back({m_is_load[dt], m_addr[dt], d});
                exp_cyc_q.push_back(cyc + 1);
                m_valid[dt] = 0;
            end else begin
                m_orphan = 1;
            end
        end
        if ((is || ls) && tt != 0) begin
            if (m_valid[tt]) m_orphan = 1;
            m_valid[tt] = 1;
            m_is_load[tt] = ls;
            m_addr[tt] = a;
        end
        @(posedge clock); #1;
        chk("outstanding", outstanding, model_count());
        chk("orphan_err", orphan_err, m_orphan);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 32'h0, 4'd0, 64'h0, 4'd0);
    endtask

    task automatic do_reset();
        reset = 1;
        icache_req_sent = 1'($urandom); load_req_sent = 0; store_req_sent = 0;
        proc2mem_addr = $urandom; mem2proc_transaction_tag = 4'($urandom_range(1, 15));
        mem2proc_data = {$urandom, $urandom}; mem2proc_data_tag = 4'($urandom_range(1, 15));
        model_clear();
        @(posedge clock); #1;
        m_ic_cnt = 0; m_ld_cnt = 0;
        reset = 0;
        chk("reset_outstanding", outstanding, 5'd0);
        chk("reset_orphan", orphan_err, 1'b0);
    endtask

    function automatic logic [3:0] pick_valid();
        logic [3:0] v[$];
        for (int i = 1; i < 16; i++) if (m_valid[i]) v.push_back(4'(i));
        if (v.size() == 0) return 4'd0;
        return v[$urandom_range(0, v.size() - 1)];
    endfunction

    function automatic logic [3:0] pick_free();
        logic [3:0] v[$];
        for (int i = 1; i < 16; i++) if (!m_valid[i]) v.push_back(4'(i));
        if (v.size() == 0) return 4'($urandom_range(1, 15));
        return v[$urandom_range(0, v.size() - 1)];
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        reset = 1;
        icache_req_sent = 0; load_req_sent = 0; store_req_sent = 0;
        proc2mem_addr = 0; mem2proc_transaction_tag = 0; mem2proc_data = 0; mem2proc_data_tag = 0;
        model_clear(); m_ic_cnt = 0; m_ld_cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_resp_val", {icache_resp_val, load_resp_val}, 2'b00);
        chk("rst_resp_bus", {icache_resp_addr, icache_resp_data, load_resp_addr, load_resp_data}, '0);
        chk("rst_outstanding", outstanding, 5'd0);
        chk("rst_orphan", orphan_err, 1'b0);
        reset = 0;

        // icache tag 3 round trip
        drive_cycle(1, 0, 0, 32'h100, 4'd3, 64'h0, 4'd0);
        drive_cycle(0, 0, 0, 32'h0, 4'd0, 64'hDEAD, 4'd3);
        idle(1);

        // rejected load, then nothing comes back
        drive_cycle(0, 1, 0, 32'h180, 4'd0, 64'h0, 4'd0);
        idle(2);

        // store tag 5 never tracked; its data is an orphan
        drive_cycle(0, 0, 1, 32'h500, 4'd5, 64'h0, 4'd0);
        drive_cycle(0, 0, 0, 32'h0, 4'd0, 64'h5555, 4'd5);
        idle(1);
        do_reset();

        // same-cycle retire and re-allocate of tag 2
        drive_cycle(0, 1, 0, 32'h200, 4'd2, 64'h0, 4'd0);
        drive_cycle(1, 0, 0, 32'h300, 4'd2, 64'hBEEF, 4'd2);
        drive_cycle(0, 0, 0, 32'h0, 4'd0, 64'hCAFE, 4'd2);
        idle(1);

        // retire one tag while allocating another
        drive_cycle(1, 0, 0, 32'h700, 4'd7, 64'h0, 4'd0);
        drive_cycle(0, 1, 0, 32'h800, 4'd8, 64'h7777, 4'd7);
        drive_cycle(0, 0, 0, 32'h0, 4'd0, 64'h8888, 4'd8);

        // simultaneous icache+load issue behaves as a load
        drive_cycle(1, 1, 0, 32'h600, 4'd6, 64'h0, 4'd0);
        drive_cycle(0, 0, 0, 32'h0, 4'd0, 64'h6666, 4'd6);
        idle(1);

        // overwrite of a live entry flags an orphan
        drive_cycle(1, 0, 0, 32'h900, 4'd9, 64'h0, 4'd0);
        drive_cycle(0, 1, 0, 32'h940, 4'd9, 64'h0, 4'd0);
        drive_cycle(0, 0, 0, 32'h0, 4'd0, 64'h9999, 4'd9);
        do_reset();

        // fill every tag, reset mid-stream, then a stale tag returns
        for (int t = 1; t < 16; t++) drive_cycle(t % 2, (t + 1) % 2, 0, 32'h1000 + 32'(t), 4'(t), 64'h0, 4'd0);
        do_reset();
        drive_cycle(0, 0, 0, 32'h0, 4'd0, 64'h4444, 4'd4);
        idle(1);
        do_reset();

`ifdef MEM_RESP_STATS_EN
        for (int t = 1; t <= 5; t++) drive_cycle(t <= 3, t > 3, 0, 32'h2000 + 32'(t), 4'(t), 64'h0, 4'd0);
        for (int t = 1; t <= 5; t++) drive_cycle(0, 0, 0, 32'h0, 4'd0, {32'h0, 32'(t)}, 4'(t));
        idle(2);
        chk("icache_resp_cnt", icache_resp_cnt, 32'd3);
        chk("load_resp_cnt", load_resp_cnt, 32'd2);
        do_reset();
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int kind;
            logic [3:0] tt, dt;
            int r;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                continue;
            end
            kind = $urandom_range(0, 3);
            tt = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : pick_free();
            r = $urandom_range(0, 9);
            if (r < 4)      dt = 4'd0;
            else if (r < 9) dt = pick_valid();
            else            dt = 4'($urandom_range(1, 15));
            drive_cycle(kind == 1, kind == 2, kind == 3, $urandom, tt, {$urandom, $urandom}, dt);
        end
        idle(3);
`ifdef MEM_RESP_STATS_EN
        chk("icache_resp_cnt_end", icache_resp_cnt, 32'(m_ic_cnt));
        chk("load_resp_cnt_end", load_resp_cnt, 32'(m_ld_cnt));
`endif
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
